// File: rtl/bumpy_controller.sv
// Bumpy movement-state controller: arbitrates death, wall bounces and player keys once
// per frame, and times reset/bounce/death intervals in frames while tracking lives.
module bumpy_controller #(
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned RESET_FRAMES  = 8,
    parameter int unsigned BOUNCE_FRAMES = 12,
    parameter int unsigned DIE_FRAMES    = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       hit_left_wall,
    input  logic       hit_right_wall,
    input  logic       hit_top_wall,
    input  logic       hit_hazard,
    output logic [3:0] state,
    output logic [2:0] lives,
    output logic       game_over,
    output logic       die_pulse
);

    localparam int unsigned TIMER_W = 16;

    typedef enum logic [3:0] {
        S_RESET       = 4'd0,
        S_IDLE        = 4'd1,
        S_LEFT        = 4'd2,
        S_RIGHT       = 4'd3,
        S_DOWN        = 4'd4,
        S_UP          = 4'd5,
        S_DIE         = 4'd6,
        S_BOUNCE_LEFT = 4'd7,
        S_BOUNCE_RGHT = 4'd8,
        S_BOUNCE_TOP  = 4'd9
    } state_e;

    localparam logic [TIMER_W-1:0] RESET_T  = TIMER_W'(RESET_FRAMES);
    localparam logic [TIMER_W-1:0] BOUNCE_T = TIMER_W'(BOUNCE_FRAMES);
    localparam logic [TIMER_W-1:0] DIE_T    = TIMER_W'(DIE_FRAMES);
    localparam logic [TIMER_W-1:0] ONE_T    = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] ZERO_T   = TIMER_W'(0);

    state_e             state_q, state_d, next_s;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         lives_q, lives_d;
    logic               game_over_q, game_over_d;
    logic               die_pulse_q, die_pulse_d;
    // flag order: {hazard, top, left, right}
    logic [3:0]         flags_q, flags_d;
    logic [3:0]         hits_s;
    logic               haz_s, top_s, lft_s, rgt_s;
    logic               expired_s, reload_s;

    // Priority list shared by the free states and by bounce expiry.
    function automatic state_e free_next(
        input logic haz, input logic top, input logic lft, input logic rgt,
        input logic kl, input logic kr, input logic ku, input logic kd
    );
        state_e nxt;
        if (haz) begin
            nxt = S_DIE;
        end else if (top) begin
            nxt = S_BOUNCE_TOP;
        end else if (lft) begin
            nxt = S_BOUNCE_LEFT;
        end else if (rgt) begin
            nxt = S_BOUNCE_RGHT;
        end else if (kl ^ kr) begin
            nxt = kl ? S_LEFT : S_RIGHT;
        end else if (ku ^ kd) begin
            nxt = ku ? S_UP : S_DOWN;
        end else begin
            nxt = S_IDLE;
        end
        return nxt;
    endfunction

    // Frame count a state starts with when it is (re)entered.
    function automatic logic [TIMER_W-1:0] load_value(input state_e s);
        logic [TIMER_W-1:0] v;
        case (s)
            S_RESET:                                   v = RESET_T;
            S_BOUNCE_LEFT, S_BOUNCE_RGHT, S_BOUNCE_TOP: v = BOUNCE_T;
            S_DIE:                                     v = DIE_T;
            default:                                   v = ZERO_T;
        endcase
        return v;
    endfunction

    assign hits_s = {hit_hazard, hit_top_wall, hit_left_wall, hit_right_wall};

    // Next-state, timer, lives and sticky-flag computation.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        lives_d     = lives_q;
        game_over_d = game_over_q;
        die_pulse_d = 1'b0;
        flags_d     = flags_q | hits_s;
        next_s      = state_q;
        reload_s    = 1'b0;
        haz_s       = flags_q[3] | hits_s[3];
        top_s       = flags_q[2] | hits_s[2];
        lft_s       = flags_q[1] | hits_s[1];
        rgt_s       = flags_q[0] | hits_s[0];
        expired_s   = (timer_q == ONE_T);

        if (startOfFrame) begin
            // a hit in the SOF cycle is consumed here, never carried over
            flags_d = 4'b0000;
            case (state_q)
                S_RESET: begin
                    if (expired_s) begin
                        next_s   = S_IDLE;
                        reload_s = 1'b1;
                    end else begin
                        next_s = S_RESET;
                    end
                end
                S_IDLE, S_LEFT, S_RIGHT, S_DOWN, S_UP: begin
                    next_s   = free_next(haz_s, top_s, lft_s, rgt_s,
                                         key_left, key_right, key_up, key_down);
                    reload_s = (next_s != state_q);
                end
                S_BOUNCE_LEFT: begin
                    reload_s = 1'b1;
                    if (haz_s)          next_s = S_DIE;
                    else if (top_s)     next_s = S_BOUNCE_TOP;
                    else if (rgt_s)     next_s = S_BOUNCE_RGHT;
                    else if (expired_s) next_s = free_next(haz_s, top_s, lft_s, rgt_s,
                                                           key_left, key_right, key_up, key_down);
                    else begin
                        next_s   = state_q;
                        reload_s = 1'b0;
                    end
                end
                S_BOUNCE_RGHT: begin
                    reload_s = 1'b1;
                    if (haz_s)          next_s = S_DIE;
                    else if (top_s)     next_s = S_BOUNCE_TOP;
                    else if (lft_s)     next_s = S_BOUNCE_LEFT;
                    else if (expired_s) next_s = free_next(haz_s, top_s, lft_s, rgt_s,
                                                           key_left, key_right, key_up, key_down);
                    else begin
                        next_s   = state_q;
                        reload_s = 1'b0;
                    end
                end
                S_BOUNCE_TOP: begin
                    reload_s = 1'b1;
                    if (haz_s)          next_s = S_DIE;
                    else if (lft_s)     next_s = S_BOUNCE_LEFT;
                    else if (rgt_s)     next_s = S_BOUNCE_RGHT;
                    else if (expired_s) next_s = free_next(haz_s, top_s, lft_s, rgt_s,
                                                           key_left, key_right, key_up, key_down);
                    else begin
                        next_s   = state_q;
                        reload_s = 1'b0;
                    end
                end
                S_DIE: begin
                    // with no lives left Sdie becomes terminal and the timer runs down to 0
                    if (expired_s && (lives_q != 3'd0)) begin
                        next_s   = S_RESET;
                        reload_s = 1'b1;
                    end else if (expired_s) begin
                        next_s      = S_DIE;
                        game_over_d = 1'b1;
                    end else begin
                        next_s = S_DIE;
                    end
                end
                default: begin
                    next_s   = S_RESET;
                    reload_s = 1'b1;
                end
            endcase

            state_d = next_s;
            if (reload_s) begin
                timer_d = load_value(next_s);
            end else if (timer_q != ZERO_T) begin
                timer_d = timer_q - ONE_T;
            end else begin
                timer_d = ZERO_T;
            end

            if (reload_s && (next_s == S_DIE)) begin
                lives_d     = (lives_q == 3'd0) ? 3'd0 : (lives_q - 3'd1);
                die_pulse_d = 1'b1;
            end else begin
                lives_d     = lives_q;
                die_pulse_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, timer, lives, flags and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_RESET;
            timer_q     <= RESET_T;
            lives_q     <= 3'(INIT_LIVES);
            game_over_q <= 1'b0;
            die_pulse_q <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            die_pulse_q <= die_pulse_d;
            flags_q     <= flags_d;
        end
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign die_pulse = die_pulse_q;

endmodule

// File: tb/tb_bumpy_controller.sv
// Scoreboard bench for bumpy_controller: expected per-frame states are queued as stimulus
// is planned and popped after each start-of-frame pulse.
module tb_bumpy_controller;

    typedef struct {
        logic [3:0] st;
        logic [2:0] lv;
        logic       go;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
    logic       hit_left_wall = 1'b0, hit_right_wall = 1'b0, hit_top_wall = 1'b0, hit_hazard = 1'b0;
    logic [3:0] state, state2;
    logic [2:0] lives, lives2;
    logic       game_over, game_over2, die_pulse, die_pulse2;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];

    bumpy_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
        .hit_left_wall(hit_left_wall), .hit_right_wall(hit_right_wall),
        .hit_top_wall(hit_top_wall), .hit_hazard(hit_hazard),
        .state(state), .lives(lives), .game_over(game_over), .die_pulse(die_pulse)
    );

    bumpy_controller #(.INIT_LIVES(1)) dut2 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
        .hit_left_wall(hit_left_wall), .hit_right_wall(hit_right_wall),
        .hit_top_wall(hit_top_wall), .hit_hazard(hit_hazard),
        .state(state2), .lives(lives2), .game_over(game_over2), .die_pulse(die_pulse2)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] st, input logic [2:0] lv, input logic go);
        exp_t e;
        e.st = st;
        e.lv = lv;
        e.go = go;
        return e;
    endfunction

    // One SOF pulse; optional hits {hazard, top, left, right} driven in the same cycle.
    task automatic sof(input logic [3:0] hits);
        @(negedge clk);
        startOfFrame = 1'b1;
        {hit_hazard, hit_top_wall, hit_left_wall, hit_right_wall} = hits;
        @(negedge clk);
        startOfFrame = 1'b0;
        {hit_hazard, hit_top_wall, hit_left_wall, hit_right_wall} = 4'b0000;
    endtask

    // One-clock mid-frame collision strobe.
    task automatic strobe(input logic [3:0] hits);
        @(negedge clk);
        {hit_hazard, hit_top_wall, hit_left_wall, hit_right_wall} = hits;
        @(negedge clk);
        {hit_hazard, hit_top_wall, hit_left_wall, hit_right_wall} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || lives !== 3'd3 || game_over !== 1'b0 || die_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got state=%0d lives=%0d go=%0b dp=%0b, want 0/3/0/0",
                     state, lives, game_over, die_pulse);
        end
        n_checks++;
        if (state2 !== 4'd0 || lives2 !== 3'd1 || game_over2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state2: got state=%0d lives=%0d go=%0b, want 0/1/0",
                     state2, lives2, game_over2);
        end
        resetN = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold_no_sof: got state=%0d, want 0", state);
        end
        for (int i = 1; i <= 8; i++) exp_q.push_back(mk((i < 8) ? 4'd0 : 4'd1, 3'd3, 1'b0));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            sof(4'b0000);
            n_checks++;
            if (state !== e.st || lives !== e.lv || game_over !== e.go) begin
                n_fail++;
                $display("FAIL reset_frames: got state=%0d lives=%0d go=%0b, want %0d/%0d/%0b",
                         state, lives, game_over, e.st, e.lv, e.go);
            end
        end
    endtask

    task automatic test_keys();
        exp_t e;
        exp_q.push_back(mk(4'd2, 3'd3, 1'b0));
        exp_q.push_back(mk(4'd5, 3'd3, 1'b0));
        exp_q.push_back(mk(4'd1, 3'd3, 1'b0));
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin key_left = 1'b1; key_up = 1'b1; end
                1: key_right = 1'b1;
                default: begin key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; end
            endcase
            e = exp_q.pop_front();
            sof(4'b0000);
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL keys_step%0d: got state=%0d, want %0d", i, state, e.st);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        key_right = 1'b1;
        sof(4'b0000);
        key_right = 1'b0;
        key_down  = 1'b1;
        strobe(4'b0010);
        exp_q.push_back(mk(4'd7, 3'd3, 1'b0));
        for (int i = 1; i <= 12; i++) exp_q.push_back(mk((i < 12) ? 4'd7 : 4'd4, 3'd3, 1'b0));
        for (int i = 0; i <= 12; i++) begin
            if (i == 3) strobe(4'b0010);
            e = exp_q.pop_front();
            sof(4'b0000);
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL bounce_left_frame%0d: got state=%0d, want %0d", i, state, e.st);
            end
        end
        key_down = 1'b0;
        strobe(4'b0010);
        for (int i = 0; i <= 4; i++) exp_q.push_back(mk(4'd7, 3'd3, 1'b0));
        exp_q.push_back(mk(4'd9, 3'd3, 1'b0));
        for (int i = 1; i <= 12; i++) exp_q.push_back(mk((i < 12) ? 4'd9 : 4'd1, 3'd3, 1'b0));
        for (int i = 0; i <= 17; i++) begin
            if (i == 5) strobe(4'b0100);
            e = exp_q.pop_front();
            sof(4'b0000);
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL bounce_top_frame%0d: got state=%0d, want %0d", i, state, e.st);
            end
        end
    endtask

    task automatic test_die();
        exp_t e;
        key_left = 1'b1;
        sof(4'b0000);
        n_checks++;
        if (state !== 4'd2) begin
            n_fail++;
            $display("FAIL die_setup: got state=%0d, want 2", state);
        end
        strobe(4'b1100);
        key_left = 1'b0;
        sof(4'b0000);
        n_checks++;
        if (state !== 4'd6 || die_pulse !== 1'b1 || lives !== 3'd2) begin
            n_fail++;
            $display("FAIL die_entry: got state=%0d dp=%0b lives=%0d, want 6/1/2",
                     state, die_pulse, lives);
        end
        @(negedge clk);
        n_checks++;
        if (die_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL die_pulse_width: got dp=%0b, want 0", die_pulse);
        end
        for (int i = 1; i <= 30; i++) exp_q.push_back(mk((i < 30) ? 4'd6 : 4'd0, 3'd2, 1'b0));
        for (int i = 1; i <= 8; i++) exp_q.push_back(mk((i < 8) ? 4'd0 : 4'd1, 3'd2, 1'b0));
        exp_q.push_back(mk(4'd1, 3'd2, 1'b0));
        for (int i = 1; i <= 39; i++) begin
            e = exp_q.pop_front();
            sof((i == 38) ? 4'b1000 : 4'b0000);
            n_checks++;
            if (state !== e.st || lives !== e.lv || die_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL die_respawn_frame%0d: got state=%0d lives=%0d dp=%0b, want %0d/%0d/0",
                         i, state, lives, die_pulse, e.st, e.lv);
            end
        end
    endtask

    task automatic test_sof_hit();
        exp_t e;
        exp_q.push_back(mk(4'd8, 3'd2, 1'b0));
        for (int i = 1; i <= 12; i++) exp_q.push_back(mk((i < 12) ? 4'd8 : 4'd1, 3'd2, 1'b0));
        for (int i = 0; i <= 12; i++) begin
            e = exp_q.pop_front();
            sof((i == 0) ? 4'b0001 : 4'b0000);
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL sof_hit_frame%0d: got state=%0d, want %0d", i, state, e.st);
            end
        end
    endtask

    task automatic test_game_over();
        exp_t e, e2;
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 1; i <= 8; i++) sof(4'b0000);
        strobe(4'b1000);
        exp_q.push_back(mk(4'd6, 3'd2, 1'b0));
        exp2_q.push_back(mk(4'd6, 3'd0, 1'b0));
        for (int i = 1; i <= 35; i++) begin
            exp_q.push_back(mk((i < 30) ? 4'd6 : 4'd0, 3'd2, 1'b0));
            exp2_q.push_back(mk(4'd6, 3'd0, (i >= 30) ? 1'b1 : 1'b0));
        end
        for (int i = 0; i <= 35; i++) begin
            e  = exp_q.pop_front();
            e2 = exp2_q.pop_front();
            sof(4'b0000);
            n_checks++;
            if (state2 !== e2.st || lives2 !== e2.lv || game_over2 !== e2.go) begin
                n_fail++;
                $display("FAIL game_over_frame%0d: got state=%0d lives=%0d go=%0b, want %0d/%0d/%0b",
                         i, state2, lives2, game_over2, e2.st, e2.lv, e2.go);
            end
            n_checks++;
            if (state !== e.st || lives !== e.lv || game_over !== e.go) begin
                n_fail++;
                $display("FAIL respawn3_frame%0d: got state=%0d lives=%0d go=%0b, want %0d/%0d/%0b",
                         i, state, lives, game_over, e.st, e.lv, e.go);
            end
        end
        @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        n_checks++;
        if (state2 !== 4'd0 || lives2 !== 3'd1 || game_over2 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got state=%0d lives=%0d go=%0b, want 0/1/0",
                     state2, lives2, game_over2);
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_keys();
        test_bounce();
        test_die();
        test_sof_hit();
        test_game_over();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
